// File: rtl/shift_pkg.sv
// Shared widths, FSM state type and the carry-spill helper for the word-serial shifter.
package shift_pkg;

  localparam int WORD_W = 16;
  localparam int AMT_W  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [AMT_W:0] SPILL_BASE = 5'd16;

  // Bits pushed out of the top of a word by a left shift of amt; amt=0 spills nothing
  // and must not evaluate a full-width right shift.
  function automatic logic [WORD_W-1:0] spill_bits(input logic [WORD_W-1:0] word,
                                                   input logic [AMT_W-1:0]  amt);
    logic [AMT_W:0] rsh;
    rsh = SPILL_BASE - {1'b0, amt};
    spill_bits = (amt == '0) ? '0 : (word >> rsh);
  endfunction

endpackage

// File: rtl/barrel_shift_word_sequencer_if.sv
// Command/result handshake bundle between operand source, sequencer and writeback.
interface barrel_shift_word_sequencer_if #(parameter int NWORDS = 4);
  import shift_pkg::*;

  localparam int W = WORD_W * NWORDS;

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic [AMT_W-1:0] in_amt;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;
  logic             busy;

  modport slave (
    input  in_valid, in_data, in_amt, out_ready,
    output in_ready, out_valid, out_data, busy
  );

  modport master (
    output in_valid, in_data, in_amt, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

endinterface

// File: rtl/barrel_leftshifter_16bit.sv
// 16-bit logarithmic barrel left shifter: one conditional power-of-two stage per amount bit.
module barrel_leftshifter_16bit
  import shift_pkg::*;
(
  input  logic [WORD_W-1:0] data,
  input  logic [AMT_W-1:0]  amt,
  output logic [WORD_W-1:0] result
);

  logic [WORD_W-1:0] stage [AMT_W+1];

  assign stage[0] = data;

  generate
    for (genvar gi = 0; gi < AMT_W; gi++) begin : g_stage
      assign stage[gi+1] = amt[gi] ? (stage[gi] << (2**gi)) : stage[gi];
    end
  endgenerate

  assign result = stage[AMT_W];

endmodule

// File: rtl/barrel_shift_word_sequencer.sv
// Word-serial multi-word left shifter: one 16-bit word per cycle, LSW first, with the
// bits spilled from each word OR-ed into the next; the carry out of the top word is dropped.
module barrel_shift_word_sequencer
  import shift_pkg::*;
#(
  parameter int NWORDS = 4
)
(
  input  logic                          clk,
  input  logic                          rst_n,
  barrel_shift_word_sequencer_if.slave  bus
);

  localparam int IDX_W = $clog2(NWORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

  state_t                         state_reg;
  logic [IDX_W-1:0]               idx_reg;
  logic [WORD_W-1:0]              carry_reg;
  logic [AMT_W-1:0]               amt_reg;
  logic [NWORDS-1:0][WORD_W-1:0]  operand_reg;
  logic [NWORDS-1:0][WORD_W-1:0]  result_reg;
  logic                           in_ready_reg;
  logic                           out_valid_reg;
  logic                           busy_reg;

  logic [WORD_W-1:0] cur_word;
  logic [WORD_W-1:0] shifted_word;

  assign cur_word = operand_reg[idx_reg];

  barrel_leftshifter_16bit u_shifter (
    .data   (cur_word),
    .amt    (amt_reg),
    .result (shifted_word)
  );

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = result_reg;
  assign bus.busy      = busy_reg;

  // out_valid rises on the same edge that writes the top word, so a result is
  // presented on the NWORDS+1-th edge counting the accept edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      carry_reg     <= '0;
      amt_reg       <= '0;
      operand_reg   <= '0;
      result_reg    <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.in_valid && in_ready_reg) begin
            operand_reg  <= bus.in_data;
            amt_reg      <= bus.in_amt;
            idx_reg      <= '0;
            carry_reg    <= '0;
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b1;
            state_reg    <= SHIFT;
          end
        end
        SHIFT: begin
          result_reg[idx_reg] <= shifted_word | carry_reg;
          carry_reg           <= spill_bits(cur_word, amt_reg);
          idx_reg             <= idx_reg + 1'b1;
          if (idx_reg == LAST_IDX) begin
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: begin
          out_valid_reg <= 1'b0;
          busy_reg      <= 1'b0;
          in_ready_reg  <= 1'b1;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_barrel_shift_word_sequencer.sv
// Directed bench for the word-serial shifter: a cycle-level transaction model plus literal
// expectations for each directed command, backpressure and mid-shift reset.
module tb_barrel_shift_word_sequencer;
  import shift_pkg::*;

  localparam int NWORDS = 4;
  localparam int W      = WORD_W * NWORDS;

  logic clk = 1'b0;
  logic rst_n;

  int vectors     = 0;
  int miscompares = 0;

  // Transaction model: one command in flight, result due NWORDS edges after acceptance.
  bit           m_pend = 1'b0;
  int           m_cnt  = 0;
  logic [W-1:0] m_exp  = '0;

  barrel_shift_word_sequencer_if #(.NWORDS(NWORDS)) bus ();

  barrel_shift_word_sequencer #(.NWORDS(NWORDS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] model_shift(input logic [W-1:0] d, input logic [3:0] a);
    logic [W-1:0] r;
    r = d << a;
    return r;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend <= 1'b0;
      m_cnt  <= 0;
    end else if (!m_pend) begin
      if (bus.in_valid === 1'b1) begin
        m_pend <= 1'b1;
        m_cnt  <= 0;
        m_exp  <= model_shift(bus.in_data, bus.in_amt);
      end
    end else if (m_cnt >= NWORDS) begin
      if (bus.out_ready === 1'b1) m_pend <= 1'b0;
    end else begin
      m_cnt <= m_cnt + 1;
    end
  end

  always @(negedge clk) begin
    check("in_ready",  W'(bus.in_ready),  W'(!m_pend));
    check("busy",      W'(bus.busy),      W'(m_pend));
    check("out_valid", W'(bus.out_valid), W'(m_pend && (m_cnt >= NWORDS)));
    if (m_pend && (m_cnt >= NWORDS)) check("out_data", bus.out_data, m_exp);
  end

  // Called at a negedge with the sequencer idle; returns at the negedge after acceptance.
  task automatic send(input logic [W-1:0] d, input logic [3:0] a);
    bus.in_data  = d;
    bus.in_amt   = a;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = ~d;
    bus.in_amt   = ~a;
  endtask

  task automatic wait_valid(input string name, input logic [W-1:0] exp);
    int cycles;
    cycles = 0;
    while (bus.out_valid !== 1'b1 && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
    if (bus.out_valid !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: out_valid still %b after %0d cycles, expected 1", name,
               bus.out_valid, cycles);
    end else begin
      check({name, "_data"}, bus.out_data, exp);
      check({name, "_latency_edges"}, W'(cycles + 1), W'(NWORDS + 1));
    end
  endtask

  task automatic release_result();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_amt    = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_data",  bus.out_data, '0);
    check("rst_in_ready",  W'(bus.in_ready), W'(1));
    check("rst_out_valid", W'(bus.out_valid), W'(0));
    check("rst_busy",      W'(bus.busy), W'(0));
    rst_n = 1'b1;
    @(negedge clk);

    send(64'h1234_5678_9ABC_DEF0, 4'd0);
    wait_valid("t1_amt0", 64'h1234_5678_9ABC_DEF0);
    release_result();

    send(64'h0000_0000_0000_8000, 4'd1);
    wait_valid("t2_carry", 64'h0000_0000_0001_0000);
    release_result();

    send(64'h0000_0000_0000_FFFF, 4'd15);
    wait_valid("t3_amt15", 64'h0000_0000_7FFF_8000);
    release_result();

    send(64'h8000_0000_0000_0001, 4'd4);
    wait_valid("t4_topdrop", 64'h0000_0000_0000_0010);
    release_result();

    // Backpressure with a second command waiting at the input.
    send(64'h0123_4567_89AB_CDEF, 4'd8);
    wait_valid("t5_first", 64'h2345_6789_ABCD_EF00);
    bus.in_data  = 64'hFFFF_0000_FFFF_0000;
    bus.in_amt   = 4'd12;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t5_held_data",    bus.out_data, 64'h2345_6789_ABCD_EF00);
      check("t5_held_valid",   W'(bus.out_valid), W'(1));
      check("t5_in_ready_low", W'(bus.in_ready), W'(0));
    end
    release_result();
    check("t5_idle_in_ready", W'(bus.in_ready), W'(1));
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_amt   = '0;
    wait_valid("t5_second", 64'hF000_0FFF_F000_0000);
    release_result();

    // Reset pulsed mid-shift.
    send(64'hDEAD_BEEF_CAFE_F00D, 4'd3);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_in_ready",  W'(bus.in_ready), W'(1));
    check("t6_rst_out_valid", W'(bus.out_valid), W'(0));
    check("t6_rst_busy",      W'(bus.busy), W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("t6_no_stale_valid", W'(bus.out_valid), W'(0));
    end
    send(64'h0000_0001_0000_0001, 4'd15);
    wait_valid("t6_after_rst", 64'h0000_8000_0000_8000);
    release_result();
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
